// File: rtl/spi_slave_bus_bridge.sv
// Bridges SPI-slave commands to USI CSR strobes and a FIFO-buffered, auto-incrementing UFI burst writer.
// CSR strobe 1 clk after command, MISO after 2; UFI word 1 clk after push, held while iMUfiRdy low; full FIFO drops and flags oSOvf.

module spi_bridge_fifo #(
  parameter int pWidth = 32,
  parameter int pDepth = 16
) (
  input  logic              iSysClk,
  input  logic              iSyRst,
  input  logic              iPush,
  input  logic              iPop,
  input  logic [pWidth-1:0] iWd,
  output logic [pWidth-1:0] oRd,
  output logic              oEmpty,
  output logic              oFull
);
  localparam int pPtrBit = $clog2(pDepth);

  logic [pWidth-1:0]  rMem [pDepth];
  logic [pPtrBit-1:0] rWrPtr;
  logic [pPtrBit-1:0] rRdPtr;
  logic [pPtrBit:0]   rCnt;
  logic               doPush;
  logic               doPop;

  assign oEmpty = (rCnt == '0);
  assign oFull  = (rCnt == (pPtrBit+1)'(pDepth));
  assign doPop  = iPop && !oEmpty;
  // a full FIFO still takes a word when the head leaves in the same clk
  assign doPush = iPush && (!oFull || doPop);
  assign oRd    = rMem[rRdPtr];

  always_ff @(posedge iSysClk) begin
    if (doPush) rMem[rWrPtr] <= iWd;
  end

  always_ff @(posedge iSysClk or posedge iSyRst) begin
    if (iSyRst) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCnt   <= '0;
    end else begin
      if (doPush) rWrPtr <= rWrPtr + pPtrBit'(1);
      if (doPop)  rRdPtr <= rRdPtr + pPtrBit'(1);
      case ({doPush, doPop})
        2'b10:   rCnt <= rCnt + (pPtrBit+1)'(1);
        2'b01:   rCnt <= rCnt - (pPtrBit+1)'(1);
        default: rCnt <= rCnt;
      endcase
    end
  end
endmodule

module spi_slave_bus_bridge #(
  parameter int pBusAdrsBit = 16,
  parameter int pUfiAdrsBit = 32,
  parameter int pDataBit    = 32,
  parameter int pFifoDepth  = 16,
  parameter int pLenBit     = 16
) (
  input  logic                   iSysClk,
  input  logic                   iSyRst,
  input  logic                   iSCmdVd,
  input  logic [1:0]             iSCmd,
  input  logic [pUfiAdrsBit-1:0] iSAdrs,
  input  logic [pLenBit-1:0]     iSDLen,
  input  logic [pDataBit-1:0]    iSRd,
  input  logic                   iSRdVd,
  output logic [pDataBit-1:0]    oSMiso,
  output logic                   oSBusy,
  output logic                   oSOvf,
  input  logic [pDataBit-1:0]    iMUsiRd,
  output logic [pDataBit-1:0]    oMUsiWd,
  output logic [pBusAdrsBit-1:0] oMUsiAdrs,
  output logic                   oMUsiWEd,
  output logic                   oMUsiREd,
  output logic [pDataBit-1:0]    oMUfiWd,
  output logic [pUfiAdrsBit-1:0] oMUfiAdrs,
  output logic                   oMUfiWEd,
  output logic                   oMUfiWVd,
  input  logic                   iMUfiRdy
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] UFI_WR    = 2'd1;
  localparam logic [1:0] UFI_DRAIN = 2'd2;

  localparam logic [1:0] CMD_CSR_RD = 2'b00;
  localparam logic [1:0] CMD_CSR_WR = 2'b01;
  localparam logic [1:0] CMD_UFI_WR = 2'b11;

  localparam logic [pUfiAdrsBit-1:0] pAdrsStep = pUfiAdrsBit'(pDataBit / 8);

  logic [1:0]          rState;
  logic [pLenBit-1:0]  rRemain;
  logic                burstWord;
  logic                fifoPop;
  logic                fifoEmpty;
  logic                fifoFull;
  logic [pDataBit-1:0] fifoHead;

  assign burstWord = (rState == UFI_WR) && iSRdVd;
  assign fifoPop   = !fifoEmpty && iMUfiRdy;

  spi_bridge_fifo #(
    .pWidth (pDataBit),
    .pDepth (pFifoDepth)
  ) uFifo (
    .iSysClk (iSysClk),
    .iSyRst  (iSyRst),
    .iPush   (burstWord),
    .iPop    (fifoPop),
    .iWd     (iSRd),
    .oRd     (fifoHead),
    .oEmpty  (fifoEmpty),
    .oFull   (fifoFull)
  );

  assign oMUfiWEd = !fifoEmpty;
  assign oMUfiWd  = fifoEmpty ? '0 : fifoHead;
  assign oMUfiWVd = (rState != IDLE);
  assign oSBusy   = (rState != IDLE);

  always_ff @(posedge iSysClk or posedge iSyRst) begin
    if (iSyRst) begin
      rState    <= IDLE;
      rRemain   <= '0;
      oSMiso    <= '0;
      oSOvf     <= 1'b0;
      oMUsiWd   <= '0;
      oMUsiAdrs <= '0;
      oMUsiWEd  <= 1'b0;
      oMUsiREd  <= 1'b0;
      oMUfiAdrs <= '0;
    end else begin
      oMUsiWEd <= 1'b0;
      oMUsiREd <= 1'b0;
      if (oMUsiREd) oSMiso <= iMUsiRd;
      if (fifoPop) oMUfiAdrs <= oMUfiAdrs + pAdrsStep;

      case (rState)
        IDLE: begin
          if (iSRdVd && iSCmd == CMD_CSR_WR) begin
            oMUsiWEd  <= 1'b1;
            oMUsiWd   <= iSRd;
            oMUsiAdrs <= iSAdrs[pBusAdrsBit-1:0];
          end else if (iSCmdVd && iSCmd == CMD_CSR_RD) begin
            oMUsiREd  <= 1'b1;
            oMUsiAdrs <= iSAdrs[pBusAdrsBit-1:0];
          end else if (iSCmdVd && iSCmd == CMD_UFI_WR && iSDLen != '0) begin
            oMUfiAdrs <= iSAdrs;
            rRemain   <= iSDLen;
            oSOvf     <= 1'b0;
            rState    <= UFI_WR;
          end
        end
        UFI_WR: begin
          if (iSRdVd) begin
            if (fifoFull && !fifoPop) oSOvf <= 1'b1;
            rRemain <= rRemain - pLenBit'(1);
            if (rRemain == pLenBit'(1)) rState <= UFI_DRAIN;
          end
        end
        UFI_DRAIN: begin
          if (fifoEmpty) rState <= IDLE;
        end
        default: rState <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_bus_bridge.sv
// Scoreboard bench for spi_slave_bus_bridge: stimulus pushes expected USI/UFI/MISO values,
// a negedge monitor pops and compares them as the bridge produces output.

module tb_spi_slave_bus_bridge;
  localparam int pBusAdrsBit = 16;
  localparam int pUfiAdrsBit = 32;
  localparam int pDataBit    = 32;
  localparam int pFifoDepth  = 16;
  localparam int pLenBit     = 16;

  logic        iSysClk = 1'b0;
  logic        iSyRst;
  logic        iSCmdVd;
  logic [1:0]  iSCmd;
  logic [31:0] iSAdrs;
  logic [15:0] iSDLen;
  logic [31:0] iSRd;
  logic        iSRdVd;
  logic [31:0] oSMiso;
  logic        oSBusy;
  logic        oSOvf;
  logic [31:0] iMUsiRd;
  logic [31:0] oMUsiWd;
  logic [15:0] oMUsiAdrs;
  logic        oMUsiWEd;
  logic        oMUsiREd;
  logic [31:0] oMUfiWd;
  logic [31:0] oMUfiAdrs;
  logic        oMUfiWEd;
  logic        oMUfiWVd;
  logic        iMUfiRdy;

  spi_slave_bus_bridge #(
    .pBusAdrsBit (pBusAdrsBit),
    .pUfiAdrsBit (pUfiAdrsBit),
    .pDataBit    (pDataBit),
    .pFifoDepth  (pFifoDepth),
    .pLenBit     (pLenBit)
  ) uDut (
    .iSysClk   (iSysClk),
    .iSyRst    (iSyRst),
    .iSCmdVd   (iSCmdVd),
    .iSCmd     (iSCmd),
    .iSAdrs    (iSAdrs),
    .iSDLen    (iSDLen),
    .iSRd      (iSRd),
    .iSRdVd    (iSRdVd),
    .oSMiso    (oSMiso),
    .oSBusy    (oSBusy),
    .oSOvf     (oSOvf),
    .iMUsiRd   (iMUsiRd),
    .oMUsiWd   (oMUsiWd),
    .oMUsiAdrs (oMUsiAdrs),
    .oMUsiWEd  (oMUsiWEd),
    .oMUsiREd  (oMUsiREd),
    .oMUfiWd   (oMUfiWd),
    .oMUfiAdrs (oMUfiAdrs),
    .oMUfiWEd  (oMUfiWEd),
    .oMUfiWVd  (oMUfiWVd),
    .iMUfiRdy  (iMUfiRdy)
  );

  always #5 iSysClk = ~iSysClk;

  int          nAssert = 0;
  int          nFail   = 0;
  int          popCnt  = 0;
  logic [63:0] usiWrQ[$];
  logic [63:0] rdAdrQ[$];
  logic [63:0] misoQ[$];
  logic [63:0] ufiQ[$];
  logic        pendMiso = 1'b0;
  logic [31:0] lastMiso = '0;
  logic [63:0] monE;
  int          mCnt = 0;
  logic [31:0] mAdr = '0;

  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge iSysClk) begin
    if (!iSyRst) begin
      if (pendMiso) begin
        pendMiso = 1'b0;
        if (misoQ.size() == 0) checkVal("miso_unexp", 64'd1, 64'd0);
        else begin
          monE = misoQ.pop_front();
          lastMiso = monE[31:0];
          checkVal("miso_data", 64'(oSMiso), monE);
        end
      end
      if (oMUsiREd) begin
        checkVal("miso_hold", 64'(oSMiso), 64'(lastMiso));
        if (rdAdrQ.size() == 0) checkVal("usi_rd_unexp", 64'd1, 64'd0);
        else checkVal("usi_rd_adrs", 64'(oMUsiAdrs), rdAdrQ.pop_front());
        pendMiso = 1'b1;
      end
      if (oMUsiWEd) begin
        if (usiWrQ.size() == 0) checkVal("usi_wr_unexp", 64'd1, 64'd0);
        else begin
          monE = usiWrQ.pop_front();
          checkVal("usi_wr_adrs", 64'(oMUsiAdrs), {32'h0, monE[63:32]});
          checkVal("usi_wr_data", 64'(oMUsiWd), {32'h0, monE[31:0]});
        end
      end
      if (oMUfiWEd && iMUfiRdy) begin
        popCnt++;
        if (ufiQ.size() == 0) checkVal("ufi_unexp", 64'd1, 64'd0);
        else begin
          monE = ufiQ.pop_front();
          checkVal("ufi_adrs", 64'(oMUfiAdrs), {32'h0, monE[63:32]});
          checkVal("ufi_data", 64'(oMUfiWd), {32'h0, monE[31:0]});
        end
      end
    end
  end

  task automatic tick();
    @(posedge iSysClk);
    #1;
  endtask

  task automatic csrWr(input logic [31:0] adrs, input logic [31:0] data);
    usiWrQ.push_back({16'h0, adrs[15:0], data});
    iSRdVd = 1'b1; iSCmd = 2'b01; iSAdrs = adrs; iSRd = data;
    tick();
    iSRdVd = 1'b0;
    tick();
  endtask

  task automatic csrRd(input logic [31:0] adrs, input logic [31:0] data);
    rdAdrQ.push_back({48'h0, adrs[15:0]});
    misoQ.push_back({32'h0, data});
    iMUsiRd = data; iSCmdVd = 1'b1; iSCmd = 2'b00; iSAdrs = adrs;
    tick();
    iSCmdVd = 1'b0;
    tick();
    tick();
  endtask

  task automatic burstStart(input logic [31:0] base, input logic [15:0] len);
    if (len != 16'd0) begin
      mAdr = base;
      mCnt = 0;
    end
    iSCmdVd = 1'b1; iSCmd = 2'b11; iSAdrs = base; iSDLen = len;
    tick();
    iSCmdVd = 1'b0;
  endtask

  task automatic burstWord(input logic [31:0] d);
    logic pop;
    logic acc;
    pop = (mCnt > 0) && iMUfiRdy;
    acc = (mCnt < pFifoDepth) || pop;
    if (acc) begin
      ufiQ.push_back({mAdr, d});
      mAdr = mAdr + 32'd4;
    end
    mCnt = mCnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    iSRd = d; iSRdVd = 1'b1;
    tick();
    iSRdVd = 1'b0;
  endtask

  task automatic waitUfiEmpty(input string tag, input int maxCyc);
    int n = 0;
    while (ufiQ.size() != 0 && n < maxCyc) begin
      @(negedge iSysClk);
      #1;
      n++;
    end
    checkVal(tag, 64'(ufiQ.size()), 64'd0);
  endtask

  task automatic waitIdle(input string tag, input int maxCyc);
    int n = 0;
    @(negedge iSysClk);
    while (oSBusy && n < maxCyc) begin
      @(negedge iSysClk);
      n++;
    end
    checkVal(tag, 64'(oSBusy), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int p0;
    logic [63:0] head;
    iSyRst = 1'b1; iSCmdVd = 1'b0; iSCmd = 2'b00; iSAdrs = '0; iSDLen = '0;
    iSRd = '0; iSRdVd = 1'b0; iMUsiRd = '0; iMUfiRdy = 1'b0;
    tick();
    tick();
    iSyRst = 1'b0;
    @(negedge iSysClk);
    checkVal("rst_busy", 64'(oSBusy), 64'd0);
    checkVal("rst_ovf", 64'(oSOvf), 64'd0);
    checkVal("rst_miso", 64'(oSMiso), 64'd0);
    checkVal("rst_ufi_wed", 64'(oMUfiWEd), 64'd0);
    checkVal("rst_ufi_wvd", 64'(oMUfiWVd), 64'd0);
    checkVal("rst_ufi_adrs", 64'(oMUfiAdrs), 64'd0);
    checkVal("rst_usi_strobes", 64'({oMUsiWEd, oMUsiREd}), 64'd0);
    tick();

    // CSR traffic, including truncated address and commands that must do nothing
    csrWr(32'h0000_0012, 32'hA5A5_0001);
    csrWr(32'hABCD_0034, 32'h0000_FFFF);
    csrRd(32'h0000_0040, 32'h1234_5678);
    iSCmdVd = 1'b1; iSCmd = 2'b10; iSAdrs = 32'h77;
    tick();
    iSCmdVd = 1'b0;
    iSRdVd = 1'b1; iSCmd = 2'b00;
    tick();
    iSRdVd = 1'b0;
    @(negedge iSysClk);
    checkVal("cmd10_busy", 64'(oSBusy), 64'd0);
    checkVal("miso_kept", 64'(oSMiso), 64'h1234_5678);
    tick();
    csrRd(32'h0001_0041, 32'hCAFE_F00D);

    // plain burst with a ready sink
    iMUfiRdy = 1'b1;
    burstStart(32'h1000_0000, 16'd4);
    @(negedge iSysClk);
    checkVal("burst_wvd", 64'(oMUfiWVd), 64'd1);
    checkVal("burst_busy", 64'(oSBusy), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) burstWord(32'hD000_0000 + 32'(i));
    waitUfiEmpty("burst4_drain", 20);
    @(negedge iSysClk);
    checkVal("wvd_last_pop", 64'(oMUfiWVd), 64'd1);
    @(negedge iSysClk);
    checkVal("wvd_fall", 64'(oMUfiWVd), 64'd0);
    tick();

    // overflow under back-pressure: only the first 16 words survive
    iMUfiRdy = 1'b0;
    burstStart(32'h2000_0000, 16'd20);
    for (int i = 0; i < 20; i++) burstWord(32'hB000_0000 + 32'(i * 3));
    @(negedge iSysClk);
    checkVal("ovf_set", 64'(oSOvf), 64'd1);
    checkVal("bp_wed", 64'(oMUfiWEd), 64'd1);
    head = ufiQ[0];
    repeat (3) @(negedge iSysClk);
    checkVal("bp_head_adrs", 64'(oMUfiAdrs), {32'h0, head[63:32]});
    checkVal("bp_head_data", 64'(oMUfiWd), {32'h0, head[31:0]});
    tick();
    p0 = popCnt;
    iMUfiRdy = 1'b1;
    waitUfiEmpty("bp_drain", 40);
    repeat (3) @(negedge iSysClk);
    checkVal("bp_pop_count", 64'(popCnt - p0), 64'd16);
    checkVal("ovf_sticky", 64'(oSOvf), 64'd1);
    tick();
    waitIdle("bp_idle", 20);

    // push onto a full FIFO in the same clk as a pop is accepted
    iMUfiRdy = 1'b0;
    burstStart(32'h2100_0000, 16'd18);
    @(negedge iSysClk);
    checkVal("ovf_clear", 64'(oSOvf), 64'd0);
    tick();
    for (int i = 0; i < 16; i++) burstWord(32'hC000_0000 + 32'(i));
    iMUfiRdy = 1'b1;
    burstWord(32'hC000_0010);
    burstWord(32'hC000_0011);
    p0 = popCnt;
    waitUfiEmpty("full_pp_drain", 40);
    checkVal("full_pp_ovf", 64'(oSOvf), 64'd0);
    tick();
    waitIdle("full_pp_idle", 20);

    // zero-length burst, address wrap, commands ignored while busy
    burstStart(32'h5000_0000, 16'd0);
    @(negedge iSysClk);
    checkVal("len0_busy", 64'(oSBusy), 64'd0);
    checkVal("len0_wed", 64'(oMUfiWEd), 64'd0);
    tick();
    burstStart(32'hFFFF_FFFC, 16'd2);
    burstWord(32'h1111_1111);
    burstWord(32'h2222_2222);
    waitUfiEmpty("wrap_drain", 20);
    tick();
    waitIdle("wrap_idle", 20);
    burstStart(32'h3000_0000, 16'd3);
    burstWord(32'h3333_0000);
    iSCmdVd = 1'b1; iSCmd = 2'b00; iSAdrs = 32'h44;
    tick();
    iSCmd = 2'b11; iSAdrs = 32'h5000_0000; iSDLen = 16'd5;
    tick();
    iSCmdVd = 1'b0;
    @(negedge iSysClk);
    checkVal("ign_busy", 64'(oSBusy), 64'd1);
    tick();
    burstWord(32'h3333_0001);
    burstWord(32'h3333_0002);
    waitUfiEmpty("ign_drain", 20);
    tick();
    waitIdle("ign_idle", 20);

    // asynchronous reset in the middle of a stalled burst
    iMUfiRdy = 1'b0;
    burstStart(32'h4000_0000, 16'd8);
    for (int i = 0; i < 4; i++) burstWord(32'hE000_0000 + 32'(i));
    #2;
    iSyRst = 1'b1;
    ufiQ.delete();
    lastMiso = '0;
    #1;
    checkVal("arst_wed", 64'(oMUfiWEd), 64'd0);
    checkVal("arst_wvd", 64'(oMUfiWVd), 64'd0);
    checkVal("arst_busy", 64'(oSBusy), 64'd0);
    checkVal("arst_ufi_adrs", 64'(oMUfiAdrs), 64'd0);
    checkVal("arst_ufi_wd", 64'(oMUfiWd), 64'd0);
    checkVal("arst_miso", 64'(oSMiso), 64'd0);
    tick();
    tick();
    iSyRst = 1'b0;
    iMUfiRdy = 1'b1;
    @(negedge iSysClk);
    checkVal("post_rst_wed", 64'(oMUfiWEd), 64'd0);
    checkVal("post_rst_busy", 64'(oSBusy), 64'd0);
    tick();
    csrRd(32'h0000_0066, 32'h0BAD_BEEF);
    burstStart(32'h6000_0000, 16'd2);
    burstWord(32'h6666_0000);
    burstWord(32'h6666_0001);
    waitUfiEmpty("post_rst_drain", 20);
    tick();
    waitIdle("post_rst_idle", 20);

    checkVal("usi_wr_left", 64'(usiWrQ.size()), 64'd0);
    checkVal("usi_rd_left", 64'(rdAdrQ.size()), 64'd0);
    checkVal("miso_left", 64'(misoQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
